alu_bist: RTL
=============

# alu_bist

Synthesizable built-in self-test engine for the 32-bit ALU of the non-pipelined processor. It drives the ALU operand/control interface (`operand1`, `operand2`, `alucontrol`) through a fixed vector set and all five operations. It compares the ALU's `result`/`zero` against an internal golden model and reports pass/fail, a failure count and the first failing check. It sits beside the ALU behind a test mux, so the datapath can be checked on silicon/FPGA without a simulator.

## Interface
- `SETTLE`, default 1: cycles between driving a check and sampling the ALU (legal 1..15).
- `STOP_ON_FAIL`, default 0: if 1, the run ends at the first mismatching check.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE/DONE.
- `operand1`  out  32  ALU operand A.
- `operand2`  out  32  ALU operand B.
- `alucontrol`  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed).
- `result`  in  32  ALU result.
- `zero`  in  1  ALU zero flag.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished (level, held until next start/reset).
- `pass`  out  1  valid when `done`: `fail_count`==0.
- `fail_count`  out  6  mismatching checks, saturates at 63.
- `first_fail_idx`  out  6  index (vec*5+op) of first mismatch; 63 if none.
- `first_fail_result`  out  32  `result` captured at first mismatch; 0 if none.

## Operation
- Vector ROM, 8 pairs (A,B): v0 (0xCC,0xAA), v1 (0x30,0xC0), v2 (0xC0,0x30), v3 (0,0), v4 (0xFFFFFFFF,1), v5 (0x80000000,0x7FFFFFFF), v6 (0x12345678,0x12345678), v7 (0x7FFFFFFF,0xFFFFFFFF).
- Op order per vector: op_idx 0..4 → 000, 001, 010, 110, 111. Vector-major order gives 40 checks, index = vec*5+op_idx.
- Golden model: AND, OR, ADD/SUB mod 2^32, SLT = 1 if signed A<B else 0. Expected zero = (expected result==0).
- A check mismatches if `result`≠expected OR `zero`≠expected zero. Each check counts at most once.
- FSM states:
  - IDLE: start → DRIVE, clear counters and outputs.
  - DRIVE: 1 cycle.
  - WAIT: SETTLE cycles.
  - CHECK: 1 cycle, then → DRIVE of the next check, or → DONE after check 39 (or on mismatch when STOP_ON_FAIL=1).
  - DONE: start → DRIVE (restart with a full clear).
- Operand/control registers load on the edge entering DRIVE and hold through CHECK.
- `start` while busy: ignored.
- First mismatch latches `first_fail_idx`/`first_fail_result`. Later mismatches only increment `fail_count` (saturating).

## Timing
- Reset values (async assert, any state): state IDLE; operand1=0, operand2=0, alucontrol=000; busy=0, done=0, pass=0, fail_count=0, first_fail_idx=63, first_fail_result=0.
- `busy`=1 from the edge sampling start until the edge entering DONE. `done`/`pass` are set on that same edge.
- Each check takes SETTLE+2 cycles. A full run has `done` high after edge 40*(SETTLE+2) counted from the start-sampling edge (edge 120 for SETTLE=1).
- STOP_ON_FAIL stop on check k: `done` after edge (k+1)*(SETTLE+2).
- `result`/`zero` are sampled only in the last cycle of CHECK. Values at other times are don't-care.
- Reset mid-run: immediate return to reset values. The next run starts from check 0.
- Deassertion of `reset_n` is synchronized internally. The first start is accepted on the 2nd edge after deassertion.

## Test plan
- Correct ALU model, SETTLE=1, start pulse → done at edge 120, busy high edges 0..119, pass=1, fail_count=0, first_fail_idx=63.
- ALU with `zero` stuck at 0 → fail_count=14, first_fail_idx=4 (v0 SLT), first_fail_result=0, pass=0.
- ALU computing SLT unsigned → fail_count=3 (v4, v5, v7 SLT), first_fail_idx=24, first_fail_result=0.
- STOP_ON_FAIL=1, AND returns A|B → done at edge 3, fail_count=1, first_fail_idx=0, first_fail_result=0xEE.
- SETTLE=3, correct ALU; extra start pulses while busy → single run, done at edge 200, pass=1. A start in DONE reruns and clears the counters.
- reset_n low at edge 50 of a failing run → all outputs at reset values asynchronously. A new start gives a full fresh run.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test for the 32-bit ALU: walks 8 operand pairs x 5 ops, compares against a golden model.
// Reports pass/fail, saturating mismatch count, and index/result of the first mismatching check.
module alu_bist #(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [2:0]  alucontrol,
  input  logic [31:0] result,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [5:0]  first_fail_idx,
  output logic [31:0] first_fail_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [5:0] LP_LAST_IDX  = 6'd39;
  localparam logic [5:0] LP_NONE      = 6'd63;

  state_t      r_state;
  state_t      w_next;
  logic        r_rst_n;
  logic [3:0]  r_wait;
  logic [2:0]  r_vec;
  logic [2:0]  r_op;
  logic [5:0]  r_idx;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [2:0]  r_ctl;
  logic [5:0]  r_fail_cnt;
  logic [5:0]  r_ff_idx;
  logic [31:0] r_ff_res;

  logic        w_load;
  logic        w_first;
  logic [2:0]  w_nvec;
  logic [2:0]  w_nop;
  logic [5:0]  w_nidx;
  logic [31:0] w_exp;
  logic        w_mismatch;

  function automatic logic [63:0] vec_rom(input logic [2:0] v);
    logic [63:0] r;
    case (v)
      3'd0:    r = {32'h0000_00CC, 32'h0000_00AA};
      3'd1:    r = {32'h0000_0030, 32'h0000_00C0};
      3'd2:    r = {32'h0000_00C0, 32'h0000_0030};
      3'd3:    r = {32'h0000_0000, 32'h0000_0000};
      3'd4:    r = {32'hFFFF_FFFF, 32'h0000_0001};
      3'd5:    r = {32'h8000_0000, 32'h7FFF_FFFF};
      3'd6:    r = {32'h1234_5678, 32'h1234_5678};
      default: r = {32'h7FFF_FFFF, 32'hFFFF_FFFF};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] op_code(input logic [2:0] o);
    logic [2:0] c;
    case (o)
      3'd0:    c = 3'b000;
      3'd1:    c = 3'b001;
      3'd2:    c = 3'b010;
      3'd3:    c = 3'b110;
      3'd4:    c = 3'b111;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // Reset asserts asynchronously; release is retimed so the FSM leaves reset on a clean edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_n <= 1'b0;
    else          r_rst_n <= 1'b1;
  end

  always_comb begin
    w_exp = 32'd0;
    case (r_ctl)
      3'b000:  w_exp = r_op1 & r_op2;
      3'b001:  w_exp = r_op1 | r_op2;
      3'b010:  w_exp = r_op1 + r_op2;
      3'b110:  w_exp = r_op1 - r_op2;
      3'b111:  w_exp = {31'd0, $signed(r_op1) < $signed(r_op2)};
      default: w_exp = 32'd0;
    endcase
  end

  assign w_mismatch = (result != w_exp) || (zero != (w_exp == 32'd0));

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_first = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next  = S_DRIVE;
          w_load  = 1'b1;
          w_first = 1'b1;
        end
      end
      S_DRIVE: w_next = S_WAIT;
      S_WAIT: begin
        if (r_wait == LP_WAIT_LAST) w_next = S_CHECK;
      end
      S_CHECK: begin
        if ((r_idx == LP_LAST_IDX) || (STOP_ON_FAIL && w_mismatch)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRIVE;
          w_load = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_nvec = r_vec;
    w_nop  = r_op + 3'd1;
    w_nidx = r_idx + 6'd1;
    if (w_first) begin
      w_nvec = 3'd0;
      w_nop  = 3'd0;
      w_nidx = 6'd0;
    end else if (r_op == 3'd4) begin
      w_nvec = r_vec + 3'd1;
      w_nop  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wait     <= 4'd0;
      r_vec      <= 3'd0;
      r_op       <= 3'd0;
      r_idx      <= 6'd0;
      r_op1      <= 32'd0;
      r_op2      <= 32'd0;
      r_ctl      <= 3'b000;
      r_fail_cnt <= 6'd0;
      r_ff_idx   <= LP_NONE;
      r_ff_res   <= 32'd0;
    end else begin
      if (w_load) begin
        r_vec          <= w_nvec;
        r_op           <= w_nop;
        r_idx          <= w_nidx;
        {r_op1, r_op2} <= vec_rom(w_nvec);
        r_ctl          <= op_code(w_nop);
      end
      if (r_state == S_DRIVE)     r_wait <= 4'd0;
      else if (r_state == S_WAIT) r_wait <= r_wait + 4'd1;
      // Only the first mismatch is latched; fail_count saturates, so a zero count marks the first mismatch of a run.
      if (w_first) begin
        r_fail_cnt <= 6'd0;
        r_ff_idx   <= LP_NONE;
        r_ff_res   <= 32'd0;
      end else if ((r_state == S_CHECK) && w_mismatch) begin
        if (r_fail_cnt != 6'd63) r_fail_cnt <= r_fail_cnt + 6'd1;
        if (r_fail_cnt == 6'd0) begin
          r_ff_idx <= r_idx;
          r_ff_res <= result;
        end
      end
    end
  end

  assign operand1          = r_op1;
  assign operand2          = r_op2;
  assign alucontrol        = r_ctl;
  assign busy              = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done              = (r_state == S_DONE);
  assign pass              = done && (r_fail_cnt == 6'd0);
  assign fail_count        = r_fail_cnt;
  assign first_fail_idx    = r_ff_idx;
  assign first_fail_result = r_ff_res;

endmodule
